// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one fixed-latency FP adder between two
// requesters; latches operands, pulses add_start, captures the sum after LATENCY cycles.
`default_nettype none

module fp_add_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 33
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result_out,
    output logic             add_start,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_CNT = 6'(LATENCY - 1);

    state_t           state_q;
    logic [5:0]       count_q;
    logic             last_q;
    logic             owner_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic             start_q;
    logic             busy_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;

    // Requester 0 wins when alone, or on a tie when requester 1 was served last.
    logic w_pick0;
    assign w_pick0 = req0 && (!req1 || last_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= !w_pick0;
                        gnt0_q  <= w_pick0;
                        gnt1_q  <= !w_pick0;
                        add_a_q <= w_pick0 ? a0 : a1;
                        add_b_q <= w_pick0 ? b0 : b1;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    count_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // The adder output is valid exactly when the count reaches its last value.
                    if (count_q == C_LAST_CNT) begin
                        result_q <= add_result;
                        done0_q  <= !owner_q;
                        done1_q  <= owner_q;
                        state_q  <= S_DONE;
                    end else begin
                        count_q <= count_q + 6'd1;
                    end
                end
                S_DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign result_out = result_q;
    assign add_start  = start_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: scoreboard bench for fp_add_arbiter with LATENCY=33 and LATENCY=1 builds,
// each driven by a behavioural fixed-latency FP adder.
`default_nettype none

module tb_fp_add_arbiter;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, done0, done1, add_start, busy;
    logic [W-1:0] result_out, add_a, add_b, add_result;

    logic         req0_l = 1'b0, req1_l = 1'b0;
    logic [W-1:0] a0_l = '0, b0_l = '0, a1_l = '0, b1_l = '0;
    logic         gnt0_l, gnt1_l, done0_l, done1_l, add_start_l, busy_l;
    logic [W-1:0] result_out_l, add_a_l, add_b_l, add_result_l;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit           id;
        logic [W-1:0] res;
    } exp_t;
    exp_t sbq[$];

    fp_add_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst),
        .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result_out(result_out), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .busy(busy)
    );

    fp_add_arbiter #(.WIDTH(W), .LATENCY(1)) dut_l1 (
        .clk_in(clk), .rst_in(rst),
        .req0(req0_l), .a0(a0_l), .b0(b0_l), .req1(req1_l), .a1(a1_l), .b1(b1_l),
        .gnt0(gnt0_l), .gnt1(gnt1_l), .done0(done0_l), .done1(done1_l),
        .result_out(result_out_l), .add_start(add_start_l), .add_a(add_a_l), .add_b(add_b_l),
        .add_result(add_result_l), .busy(busy_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural adders: sum appears on add_result for exactly one cycle, garbage otherwise.
    logic [LAT-1:0] pv = '0;
    logic [W-1:0]   pd [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], add_start};
        pd[0] <= r2f(f2r(add_a) + f2r(add_b));
        for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
    end
    assign add_result = pv[LAT-1] ? pd[LAT-1] : 32'hDEADBEEF;

    logic         lv = 1'b0;
    logic [W-1:0] ld = '0;
    always @(posedge clk) begin
        lv <= add_start_l;
        ld <= r2f(f2r(add_a_l) + f2r(add_b_l));
    end
    assign add_result_l = lv ? ld : 32'hDEADBEEF;

    always @(negedge clk) begin
        if (!rst && ((gnt0 && gnt1) || (done0 && done1) || (gnt0_l && gnt1_l) || (done0_l && done1_l))) begin
            fails++;
            $display("FAIL exclusive: gnt=%b%b done=%b%b gnt_l=%b%b done_l=%b%b required no pair high",
                     gnt0, gnt1, done0, done1, gnt0_l, gnt1_l, done0_l, done1_l);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit id, output logic [W-1:0] r, output bit ok);
        ok = 1'b0; id = 1'b0; r = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                ok = 1'b1; id = done1; r = result_out;
            end
        end
    endtask

    task automatic check_pop(input string name, input bit ok, input bit id, input logic [W-1:0] r);
        exp_t e;
        tests++;
        if (!ok || sbq.size() == 0) begin
            fails++;
            $display("FAIL %s: done seen=%b queue=%0d required done and pending entry", name, ok, sbq.size());
        end else begin
            e = sbq.pop_front();
            if (id !== e.id || r !== e.res) begin
                fails++;
                $display("FAIL %s: got id=%0d result=%h required id=%0d result=%h", name, id, r, e.id, e.res);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({gnt0, gnt1, done0, done1, add_start, busy, result_out, add_a, add_b} !== '0) begin
            fails++;
            $display("FAIL reset_main: outputs=%h required 0",
                     {gnt0, gnt1, done0, done1, add_start, busy, result_out, add_a, add_b});
        end
        tests++;
        if ({gnt0_l, gnt1_l, done0_l, done1_l, add_start_l, busy_l, result_out_l, add_a_l, add_b_l} !== '0) begin
            fails++;
            $display("FAIL reset_l1: outputs nonzero required 0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c0;
        bit ok, id;
        logic [W-1:0] r;
        a0 = 32'h3F800000; b0 = 32'h40000000; req0 = 1'b1;
        sbq.push_back('{1'b0, 32'h40400000});
        @(negedge clk);
        c0 = cyc;
        tests++;
        if ({gnt0, gnt1, add_start, busy, add_a, add_b} !== {4'b1011, 32'h3F800000, 32'h40000000}) begin
            fails++;
            $display("FAIL single_grant: gnt=%b%b start=%b busy=%b a=%h b=%h required 1 0 1 1 3f800000 40000000",
                     gnt0, gnt1, add_start, busy, add_a, add_b);
        end
        @(negedge clk);
        tests++;
        if (add_start !== 1'b0) begin
            fails++;
            $display("FAIL single_start_pulse: add_start=%b required 0", add_start);
        end
        wait_done(id, r, ok);
        req0 = 1'b0;
        tests++;
        if (cyc - c0 != LAT + 1 || gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL single_latency: edges=%0d gnt1=%b required %0d 0", cyc - c0, gnt1, LAT + 1);
        end
        check_pop("single_result", ok, id, r);
        @(negedge clk);
        tests++;
        if ({gnt0, done0, busy} !== 3'b000) begin
            fails++;
            $display("FAIL single_release: gnt0=%b done0=%b busy=%b required 000", gnt0, done0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        bit ok, id;
        logic [W-1:0] r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 32'h3F800000; b0 = 32'h40000000;
        a1 = 32'h40800000; b1 = 32'h3F000000;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) sbq.push_back('{k[0], k[0] ? 32'h40900000 : 32'h40400000});
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok);
            tests++;
            if (!ok || gnt1 !== k[0] || (k > 0 && cyc - prev != LAT + 3)) begin
                fails++;
                $display("FAIL b2b_grant%0d: seen=%b gnt1=%b gap=%0d required gnt1=%b gap=%0d",
                         k, ok, gnt1, cyc - prev, k[0], LAT + 3);
            end
            prev = cyc;
            wait_done(id, r, ok);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            check_pop($sformatf("b2b_result%0d", k), ok, id, r);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_operand_hold();
        bit ok, id;
        logic [W-1:0] r;
        a0 = 32'h40000000; b0 = 32'h40400000; req0 = 1'b1;
        sbq.push_back('{1'b0, 32'h40A00000});
        wait_gnt(ok);
        repeat (5) @(negedge clk);
        a0 = 32'hBF800000;
        @(negedge clk);
        tests++;
        if (add_a !== 32'h40000000) begin
            fails++;
            $display("FAIL hold_add_a: add_a=%h required 40000000", add_a);
        end
        wait_done(id, r, ok);
        req0 = 1'b0;
        check_pop("hold_result", ok, id, r);
        @(negedge clk);
    endtask

    task automatic test_late_request();
        bit ok, id;
        logic [W-1:0] r;
        a0 = 32'h3F800000; b0 = 32'h3F800000; req0 = 1'b1;
        sbq.push_back('{1'b0, 32'h40000000});
        sbq.push_back('{1'b1, 32'h40900000});
        wait_gnt(ok);
        repeat (4) @(negedge clk);
        a1 = 32'h40800000; b1 = 32'h3F000000; req1 = 1'b1;
        wait_done(id, r, ok);
        req0 = 1'b0;
        tests++;
        if (gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL late_no_preempt: gnt1=%b at done0 required 0", gnt1);
        end
        check_pop("late_first", ok, id, r);
        @(negedge clk);
        tests++;
        if (gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL late_idle: gnt1=%b in idle cycle required 0", gnt1);
        end
        @(negedge clk);
        tests++;
        if (gnt1 !== 1'b1 || add_start !== 1'b1) begin
            fails++;
            $display("FAIL late_grant: gnt1=%b start=%b required 1 1", gnt1, add_start);
        end
        wait_done(id, r, ok);
        req1 = 1'b0;
        check_pop("late_second", ok, id, r);
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit ok, id, seen;
        int c0;
        logic [W-1:0] r;
        a0 = 32'h40400000; b0 = 32'h40400000; req0 = 1'b1;
        wait_gnt(ok);
        repeat (11) @(negedge clk);
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({gnt0, gnt1, done0, done1, add_start, busy, result_out, add_a, add_b} !== '0) begin
            fails++;
            $display("FAIL midop_reset: outputs=%h required 0",
                     {gnt0, gnt1, done0, done1, add_start, busy, result_out, add_a, add_b});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done0 || done1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL midop_no_done: done pulse seen=%b required 0", seen);
        end
        a0 = 32'h3F800000; b0 = 32'h40000000; req0 = 1'b1;
        sbq.push_back('{1'b0, 32'h40400000});
        @(negedge clk);
        c0 = cyc;
        tests++;
        if (gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL midop_regrant: gnt0=%b required 1", gnt0);
        end
        wait_done(id, r, ok);
        req0 = 1'b0;
        tests++;
        if (cyc - c0 != LAT + 1) begin
            fails++;
            $display("FAIL midop_latency: edges=%0d required %0d", cyc - c0, LAT + 1);
        end
        check_pop("midop_result", ok, id, r);
        @(negedge clk);
    endtask

    task automatic test_latency1();
        int c0;
        bit ok;
        exp_t e;
        a1_l = 32'h40400000; b1_l = 32'h40400000; req1_l = 1'b1;
        sbq.push_back('{1'b1, 32'h40C00000});
        @(negedge clk);
        c0 = cyc;
        tests++;
        if ({gnt0_l, gnt1_l, add_start_l} !== 3'b011) begin
            fails++;
            $display("FAIL l1_grant: gnt=%b%b start=%b required 0 1 1", gnt0_l, gnt1_l, add_start_l);
        end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (done0_l || done1_l) ok = 1'b1;
        end
        req1_l = 1'b0;
        e = sbq.pop_front();
        tests++;
        if (!ok || cyc - c0 != 2 || done1_l !== e.id || result_out_l !== e.res) begin
            fails++;
            $display("FAIL l1_done: seen=%b edges=%0d done1=%b result=%h required 1 2 %b %h",
                     ok, cyc - c0, done1_l, result_out_l, e.id, e.res);
        end
        @(negedge clk);
        tests++;
        if ({done1_l, gnt1_l, busy_l} !== 3'b000) begin
            fails++;
            $display("FAIL l1_release: done1=%b gnt1=%b busy=%b required 000", done1_l, gnt1_l, busy_l);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_operand_hold();
        test_late_request();
        test_reset_midop();
        test_latency1();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one multi-cycle FP adder (fixed latency, start-pulse driven, same timing as the delay element) between two requesters.
- Round-robin arbitration, operand latching and start-pulse issue.
- Counts the adder latency, captures the sum and returns it to the granted requester with a one-cycle done pulse.
- Sits between the two operand producers and the adder core.

Parameters:
- WIDTH, 32, operand/result width in bits (IEEE-754 single).
- LATENCY, 33, cycles from add_start sampled high to add_result valid; legal range 1..63.

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst_in  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 operation request (level)
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- req1  input  1  requester 1 operation request (level)
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- gnt0  output  1  requester 0 owns the adder
- gnt1  output  1  requester 1 owns the adder
- done0  output  1  one-cycle pulse: result_out valid for requester 0
- done1  output  1  one-cycle pulse: result_out valid for requester 1
- result_out  output  WIDTH  captured sum; holds until next capture
- add_start  output  1  one-cycle start pulse to adder
- add_a  output  WIDTH  registered operand A to adder
- add_b  output  WIDTH  registered operand B to adder
- add_result  input  WIDTH  adder sum, valid LATENCY cycles after start
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is asynchronous and active-high.
- Reset values: state IDLE; gnt0, gnt1, done0, done1, add_start, busy = 0; result_out, add_a, add_b = 0; count = 0; last_served = 1 (so req0 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs registered.
- IDLE: requests are sampled only in this state.
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester not equal to last_served.
  - On grant (edge E0): latch that requester's a/b into add_a/add_b, set its gnt, go ISSUE.
- ISSUE: add_start = 1 for exactly this cycle. At edge E1: count <= 0, go WAIT.
- WAIT: count increments each edge.
  - At the edge where count == LATENCY-1 (edge E1+LATENCY): result_out <= add_result, assert the granted requester's done, go DONE.
- DONE: done high for exactly this one cycle.
  - At the next edge: gnt cleared, done cleared, last_served <= granted id, go IDLE.
- Latency: grant edge to done-high cycle = LATENCY+1 edges. A single request issued back-to-back gets one op per LATENCY+3 cycles.
- Requester contract:
  - Hold req and operands stable until done is seen.
  - Deassert req no later than the DONE cycle. A req still high when IDLE samples it is a new operation.
- Operands are latched at grant; later changes on a*/b* do not affect the op in flight.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.
- The non-granted requester's req is ignored until return to IDLE. No preemption.
- LATENCY == 1: WAIT lasts one cycle; capture at E2.
- count is 6 bits and never wraps: it resets on ISSUE and stops at LATENCY-1.
- Reset mid-operation: op abandoned, no done emitted, all state back to reset values immediately (asynchronous).

Test Plan:
- Single request: req0=1, a0=0x3F800000, b0=0x40000000, adder model returns a+b after 33 cycles.
  -> gnt0 at E0, add_start one cycle, done0 one cycle 34 edges after grant, result_out=0x40400000, gnt1/done1 stay 0.
- Tie after reset: req0=req1=1 held.
  -> grants alternate 0,1,0,1 over four ops.
  -> done alternates accordingly; each op starts exactly 36 cycles after the previous one.
- Operand change mid-op: change a0 to 0xBF800000 during WAIT.
  -> add_a unchanged; result equals the originally latched sum.
- Late request: req1 rises during requester 0's WAIT.
  -> no gnt1 until the cycle after done0; then gnt1 granted.
- Reset mid-op: assert rst_in at count=10 for 1 cycle.
  -> all outputs 0 immediately, no done pulse, next req0 granted normally.
- LATENCY=1 build: single req1.
  -> done1 2 edges after grant, captures add_result sampled at E2.
